// File: rtl/triangle_assemble.sv
// triangle_assemble: gathers rasterized vertices into triangles. Each triangle
// runs through a three-stage setup pipeline that computes its edge differences,
// bounding box, twice-area and cull decision. Survivors wait in a two-entry
// output buffer until downstream accepts them.

module triangle_assemble #(
   parameter int IMG_W = 320,
   parameter int IMG_H = 180
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [47:0]   rast_pt,
   input  logic          rast_pt_valid,
   input  logic          vtx_flush,
   input  logic          cull_backface,
   output logic [143:0]  tri_verts,
   output logic [63:0]   tri_bbox,
   output logic [34:0]   tri_area,
   output logic          tri_valid,
   input  logic          tri_ready,
   output logic [15:0]   cull_count,
   output logic          overflow
);

   localparam logic signed [15:0] C_XLIM = 16'(IMG_W - 1);
   localparam logic signed [15:0] C_YLIM = 16'(IMG_H - 1);
   localparam int ENT_W = 144 + 64 + 35;

   // Smallest of three signed coordinates.
   function automatic logic signed [15:0] min3(input logic signed [15:0] a,
                                               input logic signed [15:0] b,
                                               input logic signed [15:0] c);
      logic signed [15:0] m;
      m = (a < b) ? a : b;
      return (c < m) ? c : m;
   endfunction

   // Largest of three signed coordinates.
   function automatic logic signed [15:0] max3(input logic signed [15:0] a,
                                               input logic signed [15:0] b,
                                               input logic signed [15:0] c);
      logic signed [15:0] m;
      m = (a > b) ? a : b;
      return (c > m) ? c : m;
   endfunction

   // Pins a coordinate into the range [0, hi].
   function automatic logic signed [15:0] clampV(input logic signed [15:0] v,
                                                 input logic signed [15:0] hi);
      if (v < 16'sd0)
         return 16'sd0;
      else if (v > hi)
         return hi;
      else
         return v;
   endfunction

   // ---------------------------------------------------------------------
   // Vertex assembly and launch register
   // ---------------------------------------------------------------------
   logic [1:0]   r_count;
   logic [47:0]  r_slot0;
   logic [47:0]  r_slot1;
   logic         r_l_valid;
   logic [143:0] r_l_verts;
   logic         r_l_cull;

   // The third vertex goes straight into the launch register. New vertices can
   // then refill the slots on the very next edge without disturbing a triangle
   // that has already launched.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count   <= 2'd0;
         r_slot0   <= '0;
         r_slot1   <= '0;
         r_l_valid <= 1'b0;
         r_l_verts <= '0;
         r_l_cull  <= 1'b0;
      end else begin
         r_l_valid <= 1'b0;
         if (vtx_flush) begin
            r_count <= 2'd0;
         end else if (rast_pt_valid) begin
            case (r_count)
               2'd0: begin
                  r_slot0 <= rast_pt;
                  r_count <= 2'd1;
               end
               2'd1: begin
                  r_slot1 <= rast_pt;
                  r_count <= 2'd2;
               end
               default: begin
                  r_l_valid <= 1'b1;
                  r_l_verts <= {rast_pt, r_slot1, r_slot0};
                  r_l_cull  <= cull_backface;
                  r_count   <= 2'd0;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------
   // Stage 1: edge differences and raw bounds
   // ---------------------------------------------------------------------
   logic signed [15:0] w_x0, w_y0, w_x1, w_y1, w_x2, w_y2;
   logic signed [16:0] w_dx1, w_dy1, w_dx2, w_dy2;

   assign w_x0 = r_l_verts[15:0];
   assign w_y0 = r_l_verts[31:16];
   assign w_x1 = r_l_verts[63:48];
   assign w_y1 = r_l_verts[79:64];
   assign w_x2 = r_l_verts[111:96];
   assign w_y2 = r_l_verts[127:112];

   assign w_dx1 = {w_x1[15], w_x1} - {w_x0[15], w_x0};
   assign w_dy1 = {w_y1[15], w_y1} - {w_y0[15], w_y0};
   assign w_dx2 = {w_x2[15], w_x2} - {w_x0[15], w_x0};
   assign w_dy2 = {w_y2[15], w_y2} - {w_y0[15], w_y0};

   logic               r_s1_valid;
   logic [143:0]       r_s1_verts;
   logic               r_s1_cull;
   logic signed [16:0] r_s1_dx1, r_s1_dy1, r_s1_dx2, r_s1_dy2;
   logic signed [15:0] r_s1_xmin, r_s1_ymin, r_s1_xmax, r_s1_ymax;

   // Capture the differences that feed the area products, and the unclamped box.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_verts <= '0;
         r_s1_cull  <= 1'b0;
         r_s1_dx1   <= '0;
         r_s1_dy1   <= '0;
         r_s1_dx2   <= '0;
         r_s1_dy2   <= '0;
         r_s1_xmin  <= '0;
         r_s1_ymin  <= '0;
         r_s1_xmax  <= '0;
         r_s1_ymax  <= '0;
      end else begin
         r_s1_valid <= r_l_valid;
         r_s1_verts <= r_l_verts;
         r_s1_cull  <= r_l_cull;
         r_s1_dx1   <= w_dx1;
         r_s1_dy1   <= w_dy1;
         r_s1_dx2   <= w_dx2;
         r_s1_dy2   <= w_dy2;
         r_s1_xmin  <= min3(w_x0, w_x1, w_x2);
         r_s1_ymin  <= min3(w_y0, w_y1, w_y2);
         r_s1_xmax  <= max3(w_x0, w_x1, w_x2);
         r_s1_ymax  <= max3(w_y0, w_y1, w_y2);
      end
   end

   // ---------------------------------------------------------------------
   // Stage 2: area products, clamped box, off-screen test
   // ---------------------------------------------------------------------
   logic signed [33:0] w_p1, w_p2;
   logic               w_offscreen;
   logic [63:0]        w_bbox;

   assign w_p1 = 34'(r_s1_dx1) * 34'(r_s1_dy2);
   assign w_p2 = 34'(r_s1_dx2) * 34'(r_s1_dy1);

   assign w_offscreen = (r_s1_xmax < 16'sd0) || (r_s1_ymax < 16'sd0) ||
                        (r_s1_xmin > C_XLIM) || (r_s1_ymin > C_YLIM);

   assign w_bbox = {clampV(r_s1_ymax, C_YLIM), clampV(r_s1_xmax, C_XLIM),
                    clampV(r_s1_ymin, C_YLIM), clampV(r_s1_xmin, C_XLIM)};

   logic               r_s2_valid;
   logic [143:0]       r_s2_verts;
   logic               r_s2_cull;
   logic               r_s2_off;
   logic [63:0]        r_s2_bbox;
   logic signed [33:0] r_s2_p1, r_s2_p2;

   // The off-screen test uses the raw box, so it is settled here, before the
   // clamped box loses that information.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2_valid <= 1'b0;
         r_s2_verts <= '0;
         r_s2_cull  <= 1'b0;
         r_s2_off   <= 1'b0;
         r_s2_bbox  <= '0;
         r_s2_p1    <= '0;
         r_s2_p2    <= '0;
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_verts <= r_s1_verts;
         r_s2_cull  <= r_s1_cull;
         r_s2_off   <= w_offscreen;
         r_s2_bbox  <= w_bbox;
         r_s2_p1    <= w_p1;
         r_s2_p2    <= w_p2;
      end
   end

   // ---------------------------------------------------------------------
   // Stage 3: area, cull decision, output buffer
   // ---------------------------------------------------------------------
   logic signed [34:0] w_area;
   logic               w_cull;
   logic               w_write;
   logic               w_pop;
   logic               w_full;
   logic               w_push;
   logic [ENT_W-1:0]   w_entry;
   logic [ENT_W-1:0]   w_head;

   assign w_area  = {r_s2_p1[33], r_s2_p1} - {r_s2_p2[33], r_s2_p2};
   assign w_cull  = (w_area == 35'sd0) || r_s2_off || (r_s2_cull && w_area[34]);
   assign w_write = r_s2_valid && !w_cull;
   assign w_entry = {w_area, r_s2_bbox, r_s2_verts};

   logic [ENT_W-1:0] r_ent0, r_ent1;
   logic             r_wr_ptr, r_rd_ptr;
   logic [1:0]       r_fill;
   logic [15:0]      r_cull_count;
   logic             r_overflow;

   assign w_pop  = (r_fill != 2'd0) && tri_ready;
   assign w_full = (r_fill == 2'd2);
   assign w_push = w_write && (!w_full || w_pop);

   // A pop on the same edge frees the slot that a write into a full buffer
   // needs. Only a write that still finds no room is dropped and flagged.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ent0       <= '0;
         r_ent1       <= '0;
         r_wr_ptr     <= 1'b0;
         r_rd_ptr     <= 1'b0;
         r_fill       <= 2'd0;
         r_cull_count <= 16'd0;
         r_overflow   <= 1'b0;
      end else begin
         if (w_push) begin
            if (r_wr_ptr)
               r_ent1 <= w_entry;
            else
               r_ent0 <= w_entry;
            r_wr_ptr <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         if (w_push && !w_pop)
            r_fill <= r_fill + 2'd1;
         else if (!w_push && w_pop)
            r_fill <= r_fill - 2'd1;
         if (w_write && !w_push)
            r_overflow <= 1'b1;
         if (r_s2_valid && w_cull && (r_cull_count != 16'hFFFF))
            r_cull_count <= r_cull_count + 16'd1;
      end
   end

   assign w_head     = r_rd_ptr ? r_ent1 : r_ent0;
   assign tri_verts  = w_head[143:0];
   assign tri_bbox   = w_head[207:144];
   assign tri_area   = w_head[242:208];
   assign tri_valid  = (r_fill != 2'd0);
   assign cull_count = r_cull_count;
   assign overflow   = r_overflow;

endmodule

// File: tb/tb_triangle_assemble.sv
// tb_triangle_assemble: directed scenarios for triangle_assemble with
// hand-computed expectations. Inputs change on the falling edge, and outputs
// are sampled on the falling edge.

module tb_triangle_assemble;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [47:0]   rast_pt = '0;
   logic          rast_pt_valid = 1'b0;
   logic          vtx_flush = 1'b0;
   logic          cull_backface = 1'b0;
   logic [143:0]  tri_verts;
   logic [63:0]   tri_bbox;
   logic [34:0]   tri_area;
   logic          tri_valid;
   logic          tri_ready = 1'b0;
   logic [15:0]   cull_count;
   logic          overflow;

   int nChecks = 0;
   int nPass   = 0;

   triangle_assemble #(.IMG_W(320), .IMG_H(180)) dut (
      .clk           (clk),
      .rst           (rst),
      .rast_pt       (rast_pt),
      .rast_pt_valid (rast_pt_valid),
      .vtx_flush     (vtx_flush),
      .cull_backface (cull_backface),
      .tri_verts     (tri_verts),
      .tri_bbox      (tri_bbox),
      .tri_area      (tri_area),
      .tri_valid     (tri_valid),
      .tri_ready     (tri_ready),
      .cull_count    (cull_count),
      .overflow      (overflow)
   );

   // Free-running clock with a 10-unit period.
   always #5 clk = ~clk;

   // Packs one vertex as {z, y, x}.
   function automatic logic [47:0] mkV(input int x, input int y, input int z);
      return {z[15:0], y[15:0], x[15:0]};
   endfunction

   // Packs a box as {ymax, xmax, ymin, xmin}.
   function automatic logic [63:0] mkBox(input int xn, input int yn, input int xx, input int yx);
      return {yx[15:0], xx[15:0], yn[15:0], xn[15:0]};
   endfunction

   // Presents one vertex for the next rising edge.
   task automatic push(input int x, input int y, input int z);
      @(negedge clk);
      rast_pt       = mkV(x, y, z);
      rast_pt_valid = 1'b1;
      vtx_flush     = 1'b0;
   endtask

   // Advances one cycle with no vertex presented.
   task automatic idle();
      @(negedge clk);
      rast_pt_valid = 1'b0;
      vtx_flush     = 1'b0;
   endtask

   // Waits a bounded number of cycles for tri_valid.
   task automatic waitTri(output bit got);
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         idle();
         if (tri_valid) got = 1'b1;
      end
   endtask

   // Holds reset for two edges, then releases it.
   task automatic doReset();
      @(negedge clk);
      rst           = 1'b1;
      rast_pt_valid = 1'b0;
      vtx_flush     = 1'b0;
      cull_backface = 1'b0;
      tri_ready     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      nChecks++; if (tri_valid !== 1'b0) $display("FAIL reset_valid got=%0b want=0", tri_valid); else nPass++;
      nChecks++; if (cull_count !== 16'd0) $display("FAIL reset_cull got=%0d want=0", cull_count); else nPass++;
      nChecks++; if (overflow !== 1'b0) $display("FAIL reset_ovf got=%0b want=0", overflow); else nPass++;
      nChecks++; if (tri_verts !== 144'd0) $display("FAIL reset_verts got=%h want=0", tri_verts); else nPass++;
      nChecks++; if (tri_bbox !== 64'd0) $display("FAIL reset_bbox got=%h want=0", tri_bbox); else nPass++;
      nChecks++; if (tri_area !== 35'd0) $display("FAIL reset_area got=%h want=0", tri_area); else nPass++;
   endtask

   task automatic test_basic();
      doReset();
      tri_ready = 1'b1;
      push(10, 10, 5);
      push(50, 10, 6);
      push(10, 40, 7);
      idle();
      nChecks++; if (tri_valid !== 1'b0) $display("FAIL basic_early1 got=%0b want=0", tri_valid); else nPass++;
      idle();
      idle();
      nChecks++; if (tri_valid !== 1'b0) $display("FAIL basic_early3 got=%0b want=0", tri_valid); else nPass++;
      idle();
      nChecks++; if (tri_valid !== 1'b1) $display("FAIL basic_latency got=%0b want=1", tri_valid); else nPass++;
      nChecks++; if (tri_area !== 35'(1200)) $display("FAIL basic_area got=%0d want=1200", $signed(tri_area)); else nPass++;
      nChecks++; if (tri_bbox !== mkBox(10, 10, 50, 40)) $display("FAIL basic_bbox got=%h want=%h", tri_bbox, mkBox(10, 10, 50, 40)); else nPass++;
      nChecks++; if (tri_verts !== {mkV(10, 40, 7), mkV(50, 10, 6), mkV(10, 10, 5)})
         $display("FAIL basic_verts got=%h want=%h", tri_verts, {mkV(10, 40, 7), mkV(50, 10, 6), mkV(10, 10, 5)}); else nPass++;
      idle();
      nChecks++; if (tri_valid !== 1'b0) $display("FAIL basic_pop got=%0b want=0", tri_valid); else nPass++;
   endtask

   task automatic test_clamp();
      bit got;
      doReset();
      tri_ready = 1'b1;
      push(-20, -5, 1);
      push(100, -5, 1);
      push(-20, 200, 1);
      waitTri(got);
      nChecks++; if (got !== 1'b1) $display("FAIL clamp_emit got=%0b want=1", got); else nPass++;
      nChecks++; if (tri_area !== 35'(24600)) $display("FAIL clamp_area got=%0d want=24600", $signed(tri_area)); else nPass++;
      nChecks++; if (tri_bbox !== mkBox(0, 0, 100, 179)) $display("FAIL clamp_bbox got=%h want=%h", tri_bbox, mkBox(0, 0, 100, 179)); else nPass++;
      idle();
   endtask

   task automatic test_cull();
      int seen;
      bit got;
      doReset();
      tri_ready = 1'b1;
      // collinear
      push(0, 0, 0);
      push(10, 10, 0);
      push(20, 20, 0);
      seen = 0;
      repeat (10) begin idle(); if (tri_valid) seen++; end
      nChecks++; if (seen !== 0) $display("FAIL cull_zero_emit got=%0d want=0", seen); else nPass++;
      nChecks++; if (cull_count !== 16'd1) $display("FAIL cull_zero_count got=%0d want=1", cull_count); else nPass++;
      // clockwise with backface culling enabled only at launch
      push(10, 10, 0);
      push(10, 40, 0);
      push(50, 10, 0);
      cull_backface = 1'b1;
      idle();
      cull_backface = 1'b0;
      seen = 0;
      repeat (10) begin idle(); if (tri_valid) seen++; end
      nChecks++; if (seen !== 0) $display("FAIL cull_back_emit got=%0d want=0", seen); else nPass++;
      nChecks++; if (cull_count !== 16'd2) $display("FAIL cull_back_count got=%0d want=2", cull_count); else nPass++;
      // fully to the right of the screen
      push(400, 10, 0);
      push(410, 10, 0);
      push(400, 20, 0);
      seen = 0;
      repeat (10) begin idle(); if (tri_valid) seen++; end
      nChecks++; if (seen !== 0) $display("FAIL cull_off_emit got=%0d want=0", seen); else nPass++;
      nChecks++; if (cull_count !== 16'd3) $display("FAIL cull_off_count got=%0d want=3", cull_count); else nPass++;
      // same clockwise triangle, culling off at launch, turned on afterwards
      push(10, 10, 0);
      push(10, 40, 0);
      push(50, 10, 0);
      cull_backface = 1'b0;
      idle();
      cull_backface = 1'b1;
      waitTri(got);
      cull_backface = 1'b0;
      nChecks++; if (got !== 1'b1) $display("FAIL cull_keep_emit got=%0b want=1", got); else nPass++;
      nChecks++; if (tri_area !== 35'(-1200)) $display("FAIL cull_keep_area got=%0d want=-1200", $signed(tri_area)); else nPass++;
      nChecks++; if (cull_count !== 16'd3) $display("FAIL cull_keep_count got=%0d want=3", cull_count); else nPass++;
      idle();
   endtask

   task automatic test_backpressure();
      doReset();
      tri_ready = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         push(10, 10, t);
         push(50, 10, t);
         push(10, 40, t);
      end
      repeat (8) idle();
      nChecks++; if (overflow !== 1'b1) $display("FAIL bp_ovf got=%0b want=1", overflow); else nPass++;
      nChecks++; if (tri_valid !== 1'b1) $display("FAIL bp_valid got=%0b want=1", tri_valid); else nPass++;
      nChecks++; if (tri_verts[47:32] !== 16'd1) $display("FAIL bp_first got=%0d want=1", tri_verts[47:32]); else nPass++;
      nChecks++; if (tri_area !== 35'(1200)) $display("FAIL bp_area got=%0d want=1200", $signed(tri_area)); else nPass++;
      tri_ready = 1'b1;
      idle();
      nChecks++; if (tri_valid !== 1'b1 || tri_verts[47:32] !== 16'd2)
         $display("FAIL bp_second got=%0b/%0d want=1/2", tri_valid, tri_verts[47:32]); else nPass++;
      idle();
      nChecks++; if (tri_valid !== 1'b0) $display("FAIL bp_drained got=%0b want=0", tri_valid); else nPass++;
   endtask

   task automatic test_back_to_back();
      doReset();
      tri_ready = 1'b0;
      for (int t = 1; t <= 3; t++) begin
         push(10, 10, t);
         push(50, 10, t);
         push(10, 40, t);
      end
      idle();
      idle();
      idle();
      tri_ready = 1'b1;
      idle();
      tri_ready = 1'b0;
      nChecks++; if (overflow !== 1'b0) $display("FAIL b2b_ovf got=%0b want=0", overflow); else nPass++;
      nChecks++; if (tri_valid !== 1'b1 || tri_verts[47:32] !== 16'd2)
         $display("FAIL b2b_head got=%0b/%0d want=1/2", tri_valid, tri_verts[47:32]); else nPass++;
      tri_ready = 1'b1;
      idle();
      nChecks++; if (tri_valid !== 1'b1 || tri_verts[47:32] !== 16'd3)
         $display("FAIL b2b_third got=%0b/%0d want=1/3", tri_valid, tri_verts[47:32]); else nPass++;
      idle();
      nChecks++; if (tri_valid !== 1'b0) $display("FAIL b2b_drained got=%0b want=0", tri_valid); else nPass++;
   endtask

   task automatic test_flush();
      int seen;
      logic [143:0] firstVerts;
      logic [34:0]  firstArea;
      doReset();
      tri_ready = 1'b1;
      push(1, 1, 99);
      push(200, 2, 99);
      @(negedge clk);
      rast_pt       = mkV(300, 100, 99);
      rast_pt_valid = 1'b1;
      vtx_flush     = 1'b1;
      push(0, 0, 9);
      push(20, 0, 9);
      push(0, 20, 9);
      seen = 0;
      firstVerts = '0;
      firstArea = '0;
      repeat (12) begin
         idle();
         if (tri_valid) begin
            if (seen == 0) begin firstVerts = tri_verts; firstArea = tri_area; end
            seen++;
         end
      end
      nChecks++; if (seen !== 1) $display("FAIL flush_count got=%0d want=1", seen); else nPass++;
      nChecks++; if (firstVerts !== {mkV(0, 20, 9), mkV(20, 0, 9), mkV(0, 0, 9)})
         $display("FAIL flush_verts got=%h want=%h", firstVerts, {mkV(0, 20, 9), mkV(20, 0, 9), mkV(0, 0, 9)}); else nPass++;
      nChecks++; if (firstArea !== 35'(400)) $display("FAIL flush_area got=%0d want=400", $signed(firstArea)); else nPass++;
   endtask

   task automatic test_reset_midstream();
      int seen;
      logic [143:0] firstVerts;
      doReset();
      tri_ready = 1'b1;
      push(10, 10, 5);
      push(50, 10, 5);
      push(10, 40, 5);
      push(1, 1, 99);
      push(200, 2, 99);
      @(negedge clk);
      rst           = 1'b1;
      rast_pt_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      nChecks++; if (tri_valid !== 1'b0) $display("FAIL rstmid_valid got=%0b want=0", tri_valid); else nPass++;
      push(0, 0, 9);
      push(20, 0, 9);
      push(0, 20, 9);
      seen = 0;
      firstVerts = '0;
      repeat (12) begin
         idle();
         if (tri_valid) begin
            if (seen == 0) firstVerts = tri_verts;
            seen++;
         end
      end
      nChecks++; if (seen !== 1) $display("FAIL rstmid_count got=%0d want=1", seen); else nPass++;
      nChecks++; if (firstVerts !== {mkV(0, 20, 9), mkV(20, 0, 9), mkV(0, 0, 9)})
         $display("FAIL rstmid_verts got=%h want=%h", firstVerts, {mkV(0, 20, 9), mkV(20, 0, 9), mkV(0, 0, 9)}); else nPass++;
   endtask

   // Runs every scenario in order, then reports.
   initial begin
      test_reset();
      test_basic();
      test_clamp();
      test_cull();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_reset_midstream();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
